// File: rtl/ext_mem_bridge.sv
// ext_mem_bridge: request/response bridge from a CPU port to an off-chip memory over a narrow,
// multiplexed pad port. Define EXT_MEM_PARITY_EN to add even parity on the pad port (pad_par_out/pad_par_in).
module ext_mem_bridge #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int PAD_W    = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [PAD_W-1:0]  pad_out,
  output logic [PAD_W-1:0]  pad_oe,
  input  logic [PAD_W-1:0]  pad_in,
  output logic              pad_ale,
  output logic              pad_we,
  output logic              pad_rd,
  input  logic              pad_ack
`ifdef EXT_MEM_PARITY_EN
  ,
  output logic              pad_par_out,
  input  logic              pad_par_in
`endif
);

  localparam int ABEATS = (ADDR_W + PAD_W - 1) / PAD_W;
  localparam int DBEATS = (DATA_W + PAD_W - 1) / PAD_W;
  localparam int AW_PAD = ABEATS * PAD_W;
  localparam int DW_PAD = DBEATS * PAD_W;
  localparam int MAXB   = (ABEATS > DBEATS) ? ABEATS : DBEATS;
  localparam int BCNT_W = $clog2(MAXB + 1);
  localparam int WCNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_RDATA, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                live_q;
  logic                we_q;
  logic                err_q;
  logic [AW_PAD-1:0]   addr_q;
  logic [DW_PAD-1:0]   data_q;
  logic [BCNT_W-1:0]   beat_cnt;
  logic [WCNT_W-1:0]   wait_cnt;

  logic last_abeat, last_dbeat, wait_expired, par_bad, accept;

  // Address and write data shift out LS beat first; read beats shift in from the top.
  assign last_abeat   = (beat_cnt == BCNT_W'(ABEATS - 1));
  assign last_dbeat   = (beat_cnt == BCNT_W'(DBEATS - 1));
  assign wait_expired = (wait_cnt == WCNT_W'(WAIT_MAX - 1));
  assign accept       = (state_q == S_IDLE) && live_q && req_valid;

`ifdef EXT_MEM_PARITY_EN
  assign par_bad     = ^{pad_in, pad_par_in};
  assign pad_par_out = (|pad_oe) ? ^pad_out : 1'b0;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    pad_out   = '0;
    pad_oe    = '0;
    pad_ale   = 1'b0;
    pad_we    = 1'b0;
    pad_rd    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = live_q;
        if (accept) state_d = S_ADDR;
      end
      S_ADDR: begin
        pad_ale = 1'b1;
        pad_oe  = '1;
        pad_out = addr_q[PAD_W-1:0];
        if (last_abeat) state_d = we_q ? S_WDATA : S_RDATA;
      end
      S_WDATA: begin
        pad_we  = 1'b1;
        pad_oe  = '1;
        pad_out = data_q[PAD_W-1:0];
        if (pad_ack ? last_dbeat : wait_expired) state_d = S_RESP;
      end
      S_RDATA: begin
        pad_rd = 1'b1;
        if (pad_ack ? last_dbeat : wait_expired) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (we_q || err_q) ? '0 : data_q[DATA_W-1:0];
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q   <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      beat_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      // Holds req_ready low for the first cycle after reset so all outputs start at 0.
      live_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_q     <= req_we;
            err_q    <= 1'b0;
            addr_q   <= AW_PAD'(req_addr);
            data_q   <= DW_PAD'(req_wdata);
            beat_cnt <= '0;
            wait_cnt <= '0;
          end
        end
        S_ADDR: begin
          addr_q   <= addr_q >> PAD_W;
          beat_cnt <= last_abeat ? '0 : beat_cnt + BCNT_W'(1);
        end
        S_WDATA, S_RDATA: begin
          if (pad_ack) begin
            if (state_q == S_RDATA) begin
              data_q <= (data_q >> PAD_W) | (DW_PAD'(pad_in) << (DW_PAD - PAD_W));
              if (par_bad) err_q <= 1'b1;
            end else begin
              data_q <= data_q >> PAD_W;
            end
            beat_cnt <= beat_cnt + BCNT_W'(1);
            wait_cnt <= '0;
          end else if (wait_expired) begin
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_bridge.sv
// Self-checking bench for ext_mem_bridge: a transaction-level plan expands each request into the
// per-cycle pad/response trace the bridge must produce, and one compare process checks it every cycle.
module tb_ext_mem_bridge;

  localparam int WAIT_MAX = 15;
  localparam int NEVER    = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_we = 1'b0, pad_ack = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0, pad_in = '0;
  logic        req_ready, rsp_valid, rsp_err, pad_ale, pad_we, pad_rd;
  logic [7:0]  rsp_rdata, pad_out, pad_oe;

  logic        w_req_valid = 1'b0, w_pad_ack = 1'b0;
  logic [15:0] w_req_addr = '0, w_req_wdata = '0, w_rsp_rdata;
  logic [7:0]  w_pad_in = '0, w_pad_out, w_pad_oe;
  logic        w_req_ready, w_rsp_valid, w_rsp_err, w_pad_ale, w_pad_we, w_pad_rd;

`ifdef EXT_MEM_PARITY_EN
  logic pad_par_out, w_pad_par_out;
  logic pad_par_in = 1'b0, w_pad_par_in = 1'b0;
`endif

  ext_mem_bridge dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .pad_out(pad_out), .pad_oe(pad_oe), .pad_in(pad_in), .pad_ale(pad_ale),
    .pad_we(pad_we), .pad_rd(pad_rd), .pad_ack(pad_ack)
`ifdef EXT_MEM_PARITY_EN
    , .pad_par_out(pad_par_out), .pad_par_in(pad_par_in)
`endif
  );

  ext_mem_bridge #(.DATA_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .req_valid(w_req_valid), .req_ready(w_req_ready), .req_we(1'b0),
    .req_addr(w_req_addr), .req_wdata(w_req_wdata), .rsp_valid(w_rsp_valid), .rsp_rdata(w_rsp_rdata),
    .rsp_err(w_rsp_err), .pad_out(w_pad_out), .pad_oe(w_pad_oe), .pad_in(w_pad_in), .pad_ale(w_pad_ale),
    .pad_we(w_pad_we), .pad_rd(w_pad_rd), .pad_ack(w_pad_ack)
`ifdef EXT_MEM_PARITY_EN
    , .pad_par_out(w_pad_par_out), .pad_par_in(w_pad_par_in)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One cycle of the expected trace: inputs to apply, and outputs the bridge must show.
  typedef struct {
    logic        rv_in, we_in, ack_in, par_in;
    logic [15:0] addr_in;
    logic [7:0]  wdata_in, pin;
    logic        ready, ale, wr, rd, rv, err;
    logic [7:0]  oe, out, rdata;
  } cyc_t;

  cyc_t plan_q[$];
  cyc_t cur;
  bit   cur_valid = 1'b0;
  int   cur_idx = 0;
  int   rd_seen, we_seen, rv_at;
  logic rv_err;
  logic [7:0] rv_data;

  // Outside IDLE and outside data beats the inputs carry junk the bridge must ignore.
  function automatic cyc_t blank();
    cyc_t c;
    c = '{rv_in: 1'b1, we_in: 1'b1, ack_in: 1'b1, par_in: 1'b0, addr_in: 16'hDEAD,
          wdata_in: 8'h77, pin: 8'hEE, ready: 1'b0, ale: 1'b0, wr: 1'b0, rd: 1'b0,
          rv: 1'b0, err: 1'b0, oe: 8'h00, out: 8'h00, rdata: 8'h00};
    return c;
  endfunction

  // delay = number of cycles without ack before the ack cycle (>= WAIT_MAX: never acked).
  task automatic plan_txn(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                          input int delay, input logic [7:0] rbeat, input logic par);
    cyc_t c;
    bit   acked = 1'b0;
    bit   err;
    c = blank();
    c.rv_in = 1'b1; c.we_in = we; c.addr_in = addr; c.wdata_in = wdata; c.ready = 1'b1;
    plan_q.push_back(c);
    for (int i = 0; i < 2; i++) begin
      c = blank();
      c.ale = 1'b1; c.oe = 8'hFF; c.out = 8'(addr >> (8 * i));
      plan_q.push_back(c);
    end
    for (int k = 0; k < WAIT_MAX && !acked; k++) begin
      c = blank();
      c.ack_in = (k == delay);
      c.pin    = c.ack_in ? rbeat : 8'hEE;
      c.par_in = c.ack_in ? par : 1'b0;
      if (we) begin c.wr = 1'b1; c.oe = 8'hFF; c.out = wdata; end
      else    c.rd = 1'b1;
      acked = c.ack_in;
      plan_q.push_back(c);
    end
    err = !acked;
`ifdef EXT_MEM_PARITY_EN
    if (!we && acked && ((^rbeat) != par)) err = 1'b1;
`endif
    c = blank();
    c.rv = 1'b1; c.err = err; c.rdata = (we || err) ? 8'h00 : rbeat;
    plan_q.push_back(c);
  endtask

  task automatic drive(input cyc_t c);
    req_valid = c.rv_in; req_we = c.we_in; req_addr = c.addr_in; req_wdata = c.wdata_in;
    pad_ack = c.ack_in; pad_in = c.pin;
`ifdef EXT_MEM_PARITY_EN
    pad_par_in = c.par_in;
`endif
  endtask

  task automatic drive_idle();
    req_valid = 1'b0; pad_ack = 1'b0; pad_in = 8'h00;
`ifdef EXT_MEM_PARITY_EN
    pad_par_in = 1'b0;
`endif
  endtask

  // Plays the queued trace; stop_at >= 0 abandons it right after driving that cycle.
  task automatic run_plan(input int stop_at);
    int idx = 0;
    rd_seen = 0; we_seen = 0; rv_at = -1; rv_err = 1'bx; rv_data = 8'hxx;
    while (plan_q.size() > 0) begin
      @(posedge clk); #1;
      cur = plan_q.pop_front();
      drive(cur);
      cur_idx   = idx;
      cur_valid = (idx != stop_at);
      if (idx == stop_at) begin
        plan_q.delete();
        return;
      end
      idx++;
    end
    @(posedge clk); #1;
    cur_valid = 1'b0;
    drive_idle();
  endtask

  always @(negedge clk) begin
    if (cur_valid) begin
      check($sformatf("c%0d req_ready", cur_idx), req_ready, cur.ready);
      check($sformatf("c%0d pad_ale", cur_idx), pad_ale, cur.ale);
      check($sformatf("c%0d pad_we", cur_idx), pad_we, cur.wr);
      check($sformatf("c%0d pad_rd", cur_idx), pad_rd, cur.rd);
      check($sformatf("c%0d pad_oe", cur_idx), pad_oe, cur.oe);
      check($sformatf("c%0d pad_out", cur_idx), pad_out, cur.out);
      check($sformatf("c%0d rsp_valid", cur_idx), rsp_valid, cur.rv);
      check($sformatf("c%0d rsp_err", cur_idx), rsp_err, cur.err);
      check($sformatf("c%0d rsp_rdata", cur_idx), rsp_rdata, cur.rdata);
`ifdef EXT_MEM_PARITY_EN
      check($sformatf("c%0d pad_par_out", cur_idx), pad_par_out, (cur.oe != 8'h00) ? ^cur.out : 1'b0);
`endif
      if (pad_rd) rd_seen++;
      if (pad_we) we_seen++;
      if (rsp_valid) begin
        rv_at = cur_idx; rv_err = rsp_err; rv_data = rsp_rdata;
      end
    end
  end

  initial begin
    // Reset state
    #3;
    check("reset req_ready", req_ready, 1'b0);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset strobes", {pad_ale, pad_we, pad_rd}, 3'b000);
    check("reset pad_oe", pad_oe, 8'h00);
    check("reset pad_out", pad_out, 8'h00);
    check("reset rsp_rdata", rsp_rdata, 8'h00);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Write 0x1234 <- 0xA5, ack on the third write-strobe cycle
    plan_txn(1'b1, 16'h1234, 8'hA5, 2, 8'h00, 1'b0);
    check("model addr beat0", plan_q[1].out, 8'h34);
    check("model addr beat1", plan_q[2].out, 8'h12);
    check("model write length", plan_q.size(), 7);
    run_plan(-1);
    check("write pad_we cycles", we_seen, 3);
    check("write rsp cycle", rv_at, 6);
    check("write rsp_err", rv_err, 1'b0);

    // Read 0x00FF, immediate ack with 0x5C
    plan_txn(1'b0, 16'h00FF, 8'h00, 0, 8'h5C, 1'b0);
    run_plan(-1);
    check("read rsp_rdata", rv_data, 8'h5C);
    check("read rsp_err", rv_err, 1'b0);

    // Read that is never acked: timeout
    plan_txn(1'b0, 16'h2000, 8'h00, NEVER, 8'h00, 1'b0);
    run_plan(-1);
    check("timeout pad_rd cycles", rd_seen, 15);
    check("timeout rsp_err", rv_err, 1'b1);
    check("timeout rsp_rdata", rv_data, 8'h00);

    // Ack exactly on the last allowed cycle still succeeds
    plan_txn(1'b0, 16'h0A0B, 8'h00, WAIT_MAX - 1, 8'h66, 1'b0);
    run_plan(-1);
    check("late ack pad_rd cycles", rd_seen, 15);
    check("late ack rsp_err", rv_err, 1'b0);
    check("late ack rsp_rdata", rv_data, 8'h66);

    // Back-to-back: write, read, write timeout with no idle gap between them
    plan_txn(1'b1, 16'hBEEF, 8'h3C, 1, 8'h00, 1'b0);
    plan_txn(1'b0, 16'h0100, 8'h00, 0, 8'h81, 1'b0);
    plan_txn(1'b1, 16'hFFFF, 8'hC3, NEVER, 8'h00, 1'b0);
    run_plan(-1);
    check("b2b timeout pad_we cycles", we_seen, 2 + 15);
    check("b2b last rsp_err", rv_err, 1'b1);

    // Reset during the second address beat
    plan_txn(1'b1, 16'h4321, 8'h99, 0, 8'h00, 1'b0);
    run_plan(2);
    #1;
    check("pre-reset pad_ale", pad_ale, 1'b1);
    check("pre-reset pad_out", pad_out, 8'h43);
    rst_n = 1'b0;
    #1;
    check("mid-reset strobes", {pad_ale, pad_we, pad_rd}, 3'b000);
    check("mid-reset pad_oe", pad_oe, 8'h00);
    check("mid-reset req_ready", req_ready, 1'b0);
    drive_idle();
    repeat (2) begin
      @(negedge clk);
      check("in-reset rsp_valid", rsp_valid, 1'b0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    plan_txn(1'b1, 16'h5678, 8'h5A, 0, 8'h00, 1'b0);
    run_plan(-1);
    check("post-reset rsp cycle", rv_at, 4);
    check("post-reset rsp_err", rv_err, 1'b0);

`ifdef EXT_MEM_PARITY_EN
    // Parity: 0x03 has even weight, so pad_par_in must be 0
    plan_txn(1'b0, 16'h0033, 8'h00, 0, 8'h03, 1'b1);
    run_plan(-1);
    check("parity bad rsp_err", rv_err, 1'b1);
    check("parity bad rsp_rdata", rv_data, 8'h00);
    plan_txn(1'b0, 16'h0033, 8'h00, 0, 8'h03, 1'b0);
    run_plan(-1);
    check("parity good rsp_err", rv_err, 1'b0);
    check("parity good rsp_rdata", rv_data, 8'h03);
`endif

    // 16-bit data instance: two read beats 0xCD then 0xAB
    @(posedge clk); #1;
    w_req_valid = 1'b1; w_req_addr = 16'h0042;
    @(negedge clk);
    check("w16 req_ready", w_req_ready, 1'b1);
    @(posedge clk); #1;
    w_req_valid = 1'b0;
    @(negedge clk);
    check("w16 addr beat0", {w_pad_ale, w_pad_out}, {1'b1, 8'h42});
    @(posedge clk); #1;
    @(posedge clk); #1;
    w_pad_ack = 1'b1; w_pad_in = 8'hCD;
`ifdef EXT_MEM_PARITY_EN
    w_pad_par_in = ^w_pad_in;
`endif
    @(negedge clk);
    check("w16 beat0 pad_rd", w_pad_rd, 1'b1);
    check("w16 beat0 pad_oe", w_pad_oe, 8'h00);
    @(posedge clk); #1;
    w_pad_in = 8'hAB;
`ifdef EXT_MEM_PARITY_EN
    w_pad_par_in = ^w_pad_in;
`endif
    @(negedge clk);
    check("w16 beat1 pad_rd", w_pad_rd, 1'b1);
    @(posedge clk); #1;
    w_pad_ack = 1'b0; w_pad_in = 8'h00;
    @(negedge clk);
    check("w16 rsp_valid", w_rsp_valid, 1'b1);
    check("w16 rsp_err", w_rsp_err, 1'b0);
    check("w16 rsp_rdata", w_rsp_rdata, 16'hABCD);
    @(negedge clk);
    check("w16 ready after rsp", w_req_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
